otter_instr_encoder: RTL

Sequential RV32I instruction encoder for the Otter cores: accepts field-level commands (operation kind, registers, immediate) and emits 32-bit instruction words over a valid/ready stream. It is the inverse of the control-unit decoder and feeds self-test instruction memories, boot stubs and bench stimulus. It expands the `LI` pseudo-op into a `LUI`+`ADDI` pair when needed.

---
 rtl/otter_instr_encoder_if.sv | 30 +++
 rtl/otter_instr_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/otter_instr_encoder_if.sv
// Command/instruction stream bundle for otter_instr_encoder.
// slave = encoder side, master = command producer / word consumer.
interface otter_instr_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_kind;
  logic [2:0]  cmd_func3;
  logic        cmd_alt;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [31:0] cmd_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_last;
  logic        err;

  modport slave (
    input  cmd_valid, cmd_kind, cmd_func3, cmd_alt,
    input  cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, instr_ready,
    output cmd_ready, instr_valid, instr, instr_last, err
  );

  modport master (
    output cmd_valid, cmd_kind, cmd_func3, cmd_alt,
    output cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, instr_ready,
    input  cmd_ready, instr_valid, instr, instr_last, err
  );
endinterface

// File: rtl/otter_instr_encoder.sv
// RV32I field-level encoder with LI -> LUI+ADDI expansion.
// OTTER_ENC_CHECK_EN enables immediate range checks and err pulses.
module otter_instr_encoder #(
  parameter logic [31:0] RESET_WORD = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  otter_instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LAST} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [31:0] imm;
  logic [11:0] i12;
  logic [19:0] li_hi;
  logic [6:0]  f7;
  logic        shift;
  logic        li_small;
  logic [31:0] word;
  logic [31:0] addi;
  logic        two;
  logic        bad;
  logic        accept;
  logic        load;

  assign imm      = bus.cmd_imm;
  assign i12      = imm[11:0];
  // (imm + 0x800) >> 12 without a 32-bit adder
  assign li_hi    = imm[31:12] + {19'd0, imm[11]};
  assign f7       = bus.cmd_alt ? 7'b0100000 : 7'b0000000;
  assign shift    = (bus.cmd_func3[1:0] == 2'b01);
  assign li_small = (&imm[31:11]) | ~(|imm[31:11]);

  always_comb begin
    word = RESET_WORD;
    addi = RESET_WORD;
    two  = 1'b0;
    case (bus.cmd_kind)
      4'd0: word = {imm[31:12], bus.cmd_rd, OP_LUI};
      4'd1: word = {imm[31:12], bus.cmd_rd, OP_AUIPC};
      4'd2: word = {imm[20], imm[10:1], imm[11], imm[19:12],
                    bus.cmd_rd, OP_JAL};
      4'd3: word = {i12, bus.cmd_rs1, 3'b000, bus.cmd_rd, OP_JALR};
      4'd4: word = {imm[12], imm[10:5], bus.cmd_rs2, bus.cmd_rs1,
                    bus.cmd_func3, imm[4:1], imm[11], OP_BRANCH};
      4'd5: word = {i12, bus.cmd_rs1, bus.cmd_func3, bus.cmd_rd, OP_LOAD};
      4'd6: word = {imm[11:5], bus.cmd_rs2, bus.cmd_rs1,
                    bus.cmd_func3, imm[4:0], OP_STORE};
      4'd7: begin
        if (shift)
          word = {f7, imm[4:0], bus.cmd_rs1, bus.cmd_func3,
                  bus.cmd_rd, OP_IMM};
        else
          word = {i12, bus.cmd_rs1, bus.cmd_func3, bus.cmd_rd, OP_IMM};
      end
      4'd8: word = {f7, bus.cmd_rs2, bus.cmd_rs1, bus.cmd_func3,
                    bus.cmd_rd, OP_REG};
      4'd9: begin
        if (li_small) begin
          word = {i12, 5'd0, 3'b000, bus.cmd_rd, OP_IMM};
        end else begin
          word = {li_hi, bus.cmd_rd, OP_LUI};
          addi = {i12, bus.cmd_rd, 3'b000, bus.cmd_rd, OP_IMM};
          two  = |i12;
        end
      end
      default: word = RESET_WORD;
    endcase
  end

`ifdef OTTER_ENC_CHECK_EN
  logic i_ok, b_ok, j_ok, sh_ok;
  assign i_ok  = li_small;
  assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign sh_ok = ~(|imm[31:5]);

  always_comb begin
    bad = 1'b0;
    case (bus.cmd_kind)
      4'd0, 4'd1, 4'd8, 4'd9: bad = 1'b0;
      4'd2:                   bad = ~j_ok;
      4'd3, 4'd5, 4'd6:       bad = ~i_ok;
      4'd4:                   bad = ~b_ok;
      4'd7:                   bad = shift ? ~sh_ok : ~i_ok;
      default:                bad = 1'b1;
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  assign bus.cmd_ready = ~rst & ((state_q == IDLE) |
                         ((state_q == EMIT_LAST) & bus.instr_ready));
  assign accept = bus.cmd_valid & bus.cmd_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = accept;
      EMIT_HI: begin
        if (bus.instr_ready) begin
          instr_d = pend_q;
          last_d  = 1'b1;
          state_d = EMIT_LAST;
        end
      end
      EMIT_LAST: begin
        if (bus.instr_ready) begin
          load    = accept;
          state_d = IDLE;
          instr_d = RESET_WORD;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new command overrides the drain-to-idle defaults above
    if (load) begin
      if (bad) begin
        err_d   = 1'b1;
        state_d = IDLE;
        instr_d = RESET_WORD;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        instr_d = word;
        pend_d  = addi;
        valid_d = 1'b1;
        last_d  = ~two;
        state_d = two ? EMIT_HI : EMIT_LAST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= RESET_WORD;
      pend_q  <= RESET_WORD;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_last  = last_q;
  assign bus.err         = err_q;

endmodule
